// File: rtl/sptag_alloc_pkg.sv
// sptag_alloc_pkg
//   Shared constants for the speculative-tag allocator: tag count, one-hot
//   tag width and the width needed to count 0..SPTAG_NUM tags, plus a
//   popcount helper used for the free-tag count and branch depth.
package sptag_alloc_pkg;

  localparam int SPTAG_NUM   = 5;
  localparam int SPTAG_WIDTH = SPTAG_NUM;
  localparam int SPCNT_WIDTH = $clog2(SPTAG_NUM + 1);

  function automatic logic [SPCNT_WIDTH-1:0] sptag_popcount(input logic [SPTAG_WIDTH-1:0] v);
    logic [SPCNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SPTAG_WIDTH; i++) begin
      cnt = cnt + SPCNT_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sptag_alloc_penc2.sv
// sptag_alloc_penc2
//   Two-deep priority encoder over the free-tag vector. Returns the lowest
//   and second-lowest set bits as one-hot vectors with valid flags.
//   Ports:
//     i_free        : free-tag vector (bit set = tag available)
//     o_first       : one-hot lowest free tag, 0 if none
//     o_first_vld   : o_first holds a tag
//     o_second      : one-hot second-lowest free tag, 0 if none
//     o_second_vld  : o_second holds a tag
module sptag_alloc_penc2
  import sptag_alloc_pkg::*;
(
  input  logic [SPTAG_WIDTH-1:0] i_free,
  output logic [SPTAG_WIDTH-1:0] o_first,
  output logic                   o_first_vld,
  output logic [SPTAG_WIDTH-1:0] o_second,
  output logic                   o_second_vld
);

  always_comb begin
    o_first      = '0;
    o_second     = '0;
    o_first_vld  = 1'b0;
    o_second_vld = 1'b0;
    for (int i = 0; i < SPTAG_WIDTH; i++) begin
      if (i_free[i]) begin
        if (!o_first_vld) begin
          o_first[i]  = 1'b1;
          o_first_vld = 1'b1;
        end else if (!o_second_vld) begin
          o_second[i]  = 1'b1;
          o_second_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sptag_alloc.sv
// sptag_alloc
//   Speculative-tag allocator for the dual-issue decode stage. Grants one-hot
//   tags to up to two branches per decode group (all-or-nothing), supplies
//   each slot with the mask of outstanding tags it depends on, and returns
//   tags to the free pool on branch resolution.
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     i_id_vld/i_id_stall : decode group valid / held by downstream
//     i_id_br_1/i_id_br_2 : slot 1 (older) / slot 2 (younger) is a branch
//     o_id_sp_n           : slot n granted a tag this cycle
//     o_id_sptag_n        : one-hot granted tag, 0 if none
//     o_id_spmask_n       : outstanding tags slot n depends on
//     o_stall             : not enough free tags for the group
//     o_brdepth           : number of tags in use
//     i_exfin_br_prsucc   : branch resolved correctly, frees i_exfin_br_sptag
//     i_exfin_br_prmiss   : mispredict flush, frees every tag
//     i_exfin_br_sptag    : one-hot tag of the resolving branch
module sptag_alloc
  import sptag_alloc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_id_vld,
  input  logic                   i_id_stall,
  input  logic                   i_id_br_1,
  input  logic                   i_id_br_2,
  output logic                   o_id_sp_1,
  output logic                   o_id_sp_2,
  output logic [SPTAG_WIDTH-1:0] o_id_sptag_1,
  output logic [SPTAG_WIDTH-1:0] o_id_sptag_2,
  output logic [SPTAG_WIDTH-1:0] o_id_spmask_1,
  output logic [SPTAG_WIDTH-1:0] o_id_spmask_2,
  output logic                   o_stall,
  output logic [SPCNT_WIDTH-1:0] o_brdepth,
  input  logic                   i_exfin_br_prsucc,
  input  logic                   i_exfin_br_prmiss,
  input  logic [SPTAG_WIDTH-1:0] i_exfin_br_sptag
);

  logic [SPTAG_WIDTH-1:0] used_q, used_d;
  logic [SPTAG_WIDTH-1:0] free;
  logic [SPTAG_WIDTH-1:0] first, second;
  logic                   first_vld, second_vld;
  logic [SPCNT_WIDTH-1:0] need, nfree;
  logic                   alloc;
  logic [SPTAG_WIDTH-1:0] succ_clr;

  // Tags freed by a same-cycle prsucc are still marked used here, so they
  // only become allocatable on the following cycle.
  assign free = ~used_q;

  sptag_alloc_penc2 u_penc2 (
    .i_free       (free),
    .o_first      (first),
    .o_first_vld  (first_vld),
    .o_second     (second),
    .o_second_vld (second_vld)
  );

  always_comb begin
    need  = SPCNT_WIDTH'(i_id_vld & i_id_br_1) + SPCNT_WIDTH'(i_id_vld & i_id_br_2);
    nfree = sptag_popcount(free);

    o_stall = i_id_vld & (need > nfree) & ~i_exfin_br_prmiss;
    alloc   = i_id_vld & ~i_id_stall & ~o_stall & ~i_exfin_br_prmiss;

    o_id_sp_1 = alloc & i_id_br_1;
    o_id_sp_2 = alloc & i_id_br_2;

    o_id_sptag_1 = '0;
    o_id_sptag_2 = '0;
    if (o_id_sp_1 && first_vld) begin
      o_id_sptag_1 = first;
    end
    // Slot 2 falls back to the lowest free tag when slot 1 is not a branch.
    if (o_id_sp_2) begin
      if (i_id_br_1) begin
        if (second_vld) o_id_sptag_2 = second;
      end else begin
        if (first_vld) o_id_sptag_2 = first;
      end
    end

    o_id_spmask_1 = used_q;
    o_id_spmask_2 = used_q | o_id_sptag_1;
    o_brdepth     = sptag_popcount(used_q);

    succ_clr = i_exfin_br_prsucc ? i_exfin_br_sptag : '0;
    if (i_exfin_br_prmiss) begin
      used_d = '0;
    end else begin
      used_d = (used_q & ~succ_clr) | o_id_sptag_1 | o_id_sptag_2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end

endmodule

// File: tb/tb_sptag_alloc.sv
module tb_sptag_alloc;

  logic       clk;
  logic       rst_n;
  logic       i_id_vld, i_id_stall, i_id_br_1, i_id_br_2;
  logic       o_id_sp_1, o_id_sp_2;
  logic [4:0] o_id_sptag_1, o_id_sptag_2, o_id_spmask_1, o_id_spmask_2;
  logic       o_stall;
  logic [2:0] o_brdepth;
  logic       i_exfin_br_prsucc, i_exfin_br_prmiss;
  logic [4:0] i_exfin_br_sptag;

  int checks;
  int errors;

  // Reference model: one flag per tag saying whether it is held by an
  // unresolved branch.
  bit         in_use[5];
  logic       e_sp1, e_sp2, e_stall;
  logic [4:0] e_tag1, e_tag2, e_mask1, e_mask2;
  logic [2:0] e_depth;

  sptag_alloc dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_id_vld          (i_id_vld),
    .i_id_stall        (i_id_stall),
    .i_id_br_1         (i_id_br_1),
    .i_id_br_2         (i_id_br_2),
    .o_id_sp_1         (o_id_sp_1),
    .o_id_sp_2         (o_id_sp_2),
    .o_id_sptag_1      (o_id_sptag_1),
    .o_id_sptag_2      (o_id_sptag_2),
    .o_id_spmask_1     (o_id_spmask_1),
    .o_id_spmask_2     (o_id_spmask_2),
    .o_stall           (o_stall),
    .o_brdepth         (o_brdepth),
    .i_exfin_br_prsucc (i_exfin_br_prsucc),
    .i_exfin_br_prmiss (i_exfin_br_prmiss),
    .i_exfin_br_sptag  (i_exfin_br_sptag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] used_vec();
    logic [4:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) if (in_use[i]) v = v | (5'd1 << i);
    return v;
  endfunction

  function automatic int count_used();
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) if (in_use[i]) n++;
    return n;
  endfunction

  task automatic drive(input logic vld, input logic stl, input logic b1, input logic b2,
                       input logic succ, input logic miss, input logic [4:0] tag);
    i_id_vld          = vld;
    i_id_stall        = stl;
    i_id_br_1         = b1;
    i_id_br_2         = b2;
    i_exfin_br_prsucc = succ;
    i_exfin_br_prmiss = miss;
    i_exfin_br_sptag  = tag;
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic model_eval();
    int need, nfree, lo1, lo2;
    need  = i_id_vld ? (int'(i_id_br_1) + int'(i_id_br_2)) : 0;
    nfree = 5 - count_used();
    lo1 = -1;
    lo2 = -1;
    for (int i = 0; i < 5; i++) begin
      if (!in_use[i]) begin
        if (lo1 < 0) lo1 = i;
        else if (lo2 < 0) lo2 = i;
      end
    end
    e_stall = i_id_vld && (need > nfree) && !i_exfin_br_prmiss;
    e_sp1   = i_id_vld && !i_id_stall && !e_stall && !i_exfin_br_prmiss && i_id_br_1;
    e_sp2   = i_id_vld && !i_id_stall && !e_stall && !i_exfin_br_prmiss && i_id_br_2;
    e_tag1  = e_sp1 ? (5'd1 << lo1) : 5'd0;
    e_tag2  = e_sp2 ? (5'd1 << (i_id_br_1 ? lo2 : lo1)) : 5'd0;
    e_mask1 = used_vec();
    e_mask2 = used_vec() | e_tag1;
    e_depth = 3'(count_used());
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    #1;
    if (!rst_n || i_exfin_br_prmiss) begin
      for (int i = 0; i < 5; i++) in_use[i] = 1'b0;
    end else begin
      if (i_exfin_br_prsucc) begin
        for (int i = 0; i < 5; i++) if (i_exfin_br_sptag[i]) in_use[i] = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        if (e_tag1[i] || e_tag2[i]) in_use[i] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    advance();
    advance();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", o_brdepth); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", o_stall); end
    checks++; if ({o_id_sp_1, o_id_sp_2, o_id_sptag_1, o_id_sptag_2} !== 12'd0) begin errors++; $display("FAIL reset_grant got %b%b %b %b exp all 0", o_id_sp_1, o_id_sp_2, o_id_sptag_1, o_id_sptag_2); end
    checks++; if ({o_id_spmask_1, o_id_spmask_2} !== 10'd0) begin errors++; $display("FAIL reset_mask got %b %b exp 0", o_id_spmask_1, o_id_spmask_2); end
    advance();
  endtask

  task automatic test_first_pair();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_id_sptag_1 !== 5'b00001) begin errors++; $display("FAIL pair_tag1 got %b exp 00001", o_id_sptag_1); end
    checks++; if (o_id_sptag_2 !== 5'b00010) begin errors++; $display("FAIL pair_tag2 got %b exp 00010", o_id_sptag_2); end
    checks++; if (o_id_spmask_2 !== 5'b00001) begin errors++; $display("FAIL pair_mask2 got %b exp 00001", o_id_spmask_2); end
    checks++; if ({o_id_sp_1, o_id_sp_2} !== 2'b11) begin errors++; $display("FAIL pair_sp got %b%b exp 11", o_id_sp_1, o_id_sp_2); end
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd2) begin errors++; $display("FAIL pair_depth got %0d exp 2", o_brdepth); end
    checks++; if (o_id_spmask_1 !== 5'b00011) begin errors++; $display("FAIL pair_mask1 got %b exp 00011", o_id_spmask_1); end
    advance();
  endtask

  task automatic test_full_boundary();
    // used = 00011 on entry; fill to 01111 one branch at a time.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_id_sptag_2 !== 5'b01000) begin errors++; $display("FAIL fill_tag2 got %b exp 01000", o_id_sptag_2); end
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL full_two_stall got %b exp 1", o_stall); end
    checks++; if ({o_id_sp_1, o_id_sp_2, o_id_sptag_1, o_id_sptag_2} !== 12'd0) begin errors++; $display("FAIL full_two_grant got %b%b %b %b exp 0", o_id_sp_1, o_id_sp_2, o_id_sptag_1, o_id_sptag_2); end
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd4) begin errors++; $display("FAIL full_depth4 got %0d exp 4", o_brdepth); end
    checks++; if (o_id_sptag_1 !== 5'b10000 || o_stall !== 1'b0) begin errors++; $display("FAIL full_one_tag got %b stall %b exp 10000 stall 0", o_id_sptag_1, o_stall); end
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd5) begin errors++; $display("FAIL full_depth5 got %0d exp 5", o_brdepth); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL full_nobranch_stall got %b exp 0", o_stall); end
    advance();
  endtask

  task automatic test_prsucc_full();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00100);
    @(negedge clk);
    checks++; if (o_stall !== 1'b1 || o_id_sp_1 !== 1'b0) begin errors++; $display("FAIL succ_same_cycle stall %b sp %b exp stall 1 sp 0", o_stall, o_id_sp_1); end
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_id_sptag_1 !== 5'b00100) begin errors++; $display("FAIL succ_next_tag got %b exp 00100", o_id_sptag_1); end
    checks++; if (o_id_spmask_1 !== 5'b11011) begin errors++; $display("FAIL succ_next_mask got %b exp 11011", o_id_spmask_1); end
    advance();
  endtask

  task automatic test_prmiss();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    checks++; if (o_id_spmask_1 !== 5'b00011) begin errors++; $display("FAIL miss_pre_used got %b exp 00011", o_id_spmask_1); end
    checks++; if ({o_id_sp_1, o_id_sp_2, o_stall} !== 3'b000) begin errors++; $display("FAIL miss_grant sp %b%b stall %b exp 000", o_id_sp_1, o_id_sp_2, o_stall); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd0 || o_id_spmask_1 !== 5'd0) begin errors++; $display("FAIL miss_clear depth %0d used %b exp 0 00000", o_brdepth, o_id_spmask_1); end
    advance();
  endtask

  task automatic test_id_stall();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if ({o_id_sp_1, o_id_sp_2} !== 2'b00 || o_id_sptag_1 !== 5'd0 || o_id_sptag_2 !== 5'd0) begin errors++; $display("FAIL idstall_grant sp %b%b tags %b %b exp 0", o_id_sp_1, o_id_sp_2, o_id_sptag_1, o_id_sptag_2); end
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd0) begin errors++; $display("FAIL idstall_used got %0d exp 0", o_brdepth); end
    checks++; if (o_id_sptag_1 !== 5'b00001 || o_id_sptag_2 !== 5'b00010) begin errors++; $display("FAIL idstall_release got %b %b exp 00001 00010", o_id_sptag_1, o_id_sptag_2); end
    advance();
  endtask

  task automatic test_slot2_only();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    advance();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_id_sptag_2 !== 5'b00010) begin errors++; $display("FAIL slot2_tag got %b exp 00010", o_id_sptag_2); end
    checks++; if (o_id_sptag_1 !== 5'd0 || o_id_sp_1 !== 1'b0) begin errors++; $display("FAIL slot2_tag1 got %b sp %b exp 0", o_id_sptag_1, o_id_sp_1); end
    checks++; if (o_id_spmask_2 !== 5'b00001) begin errors++; $display("FAIL slot2_mask2 got %b exp 00001", o_id_spmask_2); end
    advance();
  endtask

  task automatic test_reset_midop();
    // used = 00011 on entry; reset with a grant and prsucc pending.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00001);
    advance();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++; if (o_brdepth !== 3'd0 || o_id_spmask_1 !== 5'd0) begin errors++; $display("FAIL midreset depth %0d used %b exp 0 00000", o_brdepth, o_id_spmask_1); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic       succ, miss;
      logic [4:0] tag;
      int         pick;
      succ = 1'b0;
      miss = ($urandom_range(0, 15) == 0);
      tag  = 5'd0;
      if (!miss && count_used() > 0 && $urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, count_used() - 1);
        for (int i = 0; i < 5; i++) begin
          if (in_use[i]) begin
            if (pick == 0) tag = 5'd1 << i;
            pick--;
          end
        end
        succ = 1'b1;
      end
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), succ, miss, tag);
      @(negedge clk);
      model_eval();
      checks++; if (o_stall !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, o_stall, e_stall); end
      checks++; if ({o_id_sp_1, o_id_sp_2} !== {e_sp1, e_sp2}) begin errors++; $display("FAIL rnd_sp n=%0d got %b%b exp %b%b", n, o_id_sp_1, o_id_sp_2, e_sp1, e_sp2); end
      checks++; if (o_id_sptag_1 !== e_tag1) begin errors++; $display("FAIL rnd_tag1 n=%0d got %b exp %b", n, o_id_sptag_1, e_tag1); end
      checks++; if (o_id_sptag_2 !== e_tag2) begin errors++; $display("FAIL rnd_tag2 n=%0d got %b exp %b", n, o_id_sptag_2, e_tag2); end
      checks++; if (o_id_spmask_1 !== e_mask1) begin errors++; $display("FAIL rnd_mask1 n=%0d got %b exp %b", n, o_id_spmask_1, e_mask1); end
      checks++; if (o_id_spmask_2 !== e_mask2) begin errors++; $display("FAIL rnd_mask2 n=%0d got %b exp %b", n, o_id_spmask_2, e_mask2); end
      checks++; if (o_brdepth !== e_depth) begin errors++; $display("FAIL rnd_depth n=%0d got %0d exp %0d", n, o_brdepth, e_depth); end
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 5; i++) in_use[i] = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    test_reset();
    test_first_pair();
    test_full_boundary();
    test_prsucc_full();
    test_prmiss();
    test_id_stall();
    test_reset_midop();
    test_slot2_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
